hamming_uart_rx_ctrl: RTL



---
 rtl/hamming_uart_rx_ctrl_if.sv | 28 ++
 rtl/hamming_uart_rx_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hamming_uart_rx_ctrl_if.sv
// Serial input and decoded-output bundle for the Hamming UART receiver.
// The slave modport is the receiver; the master modport drives rx_i and observes the results.
interface hamming_uart_rx_ctrl_if;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       corrected_o;
  logic       double_err_o;
  logic       frame_err_o;

  modport master (
    output rx_i,
    input  data_o,
    input  valid_o,
    input  corrected_o,
    input  double_err_o,
    input  frame_err_o
  );

  modport slave (
    input  rx_i,
    output data_o,
    output valid_o,
    output corrected_o,
    output double_err_o,
    output frame_err_o
  );
endinterface

// File: rtl/hamming_uart_rx_ctrl.sv
// 8N1 UART receiver that pairs bytes (high first) into SECDED(8,4)-coded nibbles
// and presents the corrected byte with corrected/double-error/frame-error status.
module hamming_uart_rx_ctrl #(
  parameter int unsigned FREQUENCY    = 32'd50_000_000,
  parameter int unsigned SPEED        = 32'd9600,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input logic                         clk_i,
  input logic                         reset_n,
  hamming_uart_rx_ctrl_if.slave       bus
);

  localparam int unsigned DIVIDER     = FREQUENCY / SPEED;
  localparam int unsigned CNT_W       = $clog2(DIVIDER + 1);
  localparam int unsigned DIV_LAST    = (DIVIDER > 0) ? DIVIDER - 1 : 0;
  localparam int unsigned HALF_LAST   = (DIVIDER / 2 > 0) ? DIVIDER / 2 - 1 : 0;
  localparam int unsigned TIMEOUT_CYC = TIMEOUT_BITS * DIVIDER;
  localparam int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned TO_LAST     = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWait} state_e;

  // Returns {corrected, double_err, nibble}; the nibble stays raw on a double error.
  function automatic logic [5:0] decode(input logic [7:0] b);
    logic [2:0] s;
    logic       p;
    logic [7:0] c;
    logic       corr;
    logic       dbl;
    s[0] = b[0] ^ b[2] ^ b[4] ^ b[6];
    s[1] = b[1] ^ b[2] ^ b[5] ^ b[6];
    s[2] = b[3] ^ b[4] ^ b[5] ^ b[6];
    p    = ^b;
    c    = b;
    corr = 1'b0;
    dbl  = 1'b0;
    if (s != 3'd0 && p) begin
      c[s - 3'd1] = ~c[s - 3'd1];
      corr        = 1'b1;
    end else if (s == 3'd0 && p) begin
      corr = 1'b1;
    end else if (s != 3'd0 && !p) begin
      dbl = 1'b1;
    end
    return {corr, dbl, c[6], c[5], c[4], c[2]};
  endfunction

  logic [2:0]       r_sync;
  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_paired;
  logic [7:0]       r_hi_byte;
  logic [7:0]       r_lo_byte;
  logic [TO_W-1:0]  r_tcnt;
  logic             r_dec_go;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_corr;
  logic             r_dbl;
  logic             r_frame_err;

  logic             w_rx;
  logic             w_fall;
  logic             w_half_done;
  logic             w_bit_done;
  logic             w_cnt_clr;
  logic             w_shift_en;
  logic             w_byte_ok;
  logic             w_stop_bad;
  logic             w_start_edge;
  logic             w_timeout;
  logic [5:0]       w_dec_hi;
  logic [5:0]       w_dec_lo;

  // r_sync[1] is the synchronised line; r_sync[2] is its previous value for edge detection.
  assign w_rx        = r_sync[1];
  assign w_fall      = r_sync[2] & ~r_sync[1];
  assign w_half_done = (r_cnt == CNT_W'(HALF_LAST));
  assign w_bit_done  = (r_cnt == CNT_W'(DIV_LAST));

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= 3'b111;
      r_state <= StIdle;
    end else begin
      r_sync  <= {r_sync[1:0], bus.rx_i};
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_fall) w_state_next = StStart;
      StStart: if (w_half_done) w_state_next = w_rx ? StIdle : StData;
      StData:  if (w_bit_done && r_bit_idx == 3'd7) w_state_next = StStop;
      StStop:  if (w_bit_done) w_state_next = w_rx ? StIdle : StWait;
      StWait:  if (w_rx) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_clr    = 1'b1;
    w_shift_en   = 1'b0;
    w_byte_ok    = 1'b0;
    w_stop_bad   = 1'b0;
    w_start_edge = 1'b0;
    case (r_state)
      StIdle:  w_start_edge = w_fall;
      StStart: w_cnt_clr = w_half_done;
      StData: begin
        w_cnt_clr  = w_bit_done;
        w_shift_en = w_bit_done;
      end
      StStop: begin
        w_cnt_clr  = w_bit_done;
        w_byte_ok  = w_bit_done & w_rx;
        w_stop_bad = w_bit_done & ~w_rx;
      end
      default: w_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (r_state != StData) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {w_rx, r_shift[7:1]};
      end
    end
  end

  // A start edge landing on the expiry cycle wins over the timeout.
  assign w_timeout = r_paired && (r_state == StIdle) && !w_fall && (r_tcnt == TO_W'(TO_LAST));

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_paired  <= 1'b0;
      r_hi_byte <= '0;
      r_lo_byte <= '0;
      r_tcnt    <= '0;
      r_dec_go  <= 1'b0;
    end else begin
      r_dec_go <= 1'b0;
      if (w_stop_bad || w_timeout) begin
        r_paired <= 1'b0;
      end else if (w_byte_ok) begin
        if (r_paired) begin
          r_lo_byte <= r_shift;
          r_dec_go  <= 1'b1;
          r_paired  <= 1'b0;
        end else begin
          r_hi_byte <= r_shift;
          r_paired  <= 1'b1;
        end
      end
      if (!r_paired || w_start_edge || r_state != StIdle) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  assign w_dec_hi = decode(r_hi_byte);
  assign w_dec_lo = decode(r_lo_byte);

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_corr      <= 1'b0;
      r_dbl       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= r_dec_go;
      r_frame_err <= w_stop_bad | w_timeout;
      if (r_dec_go) begin
        r_data <= {w_dec_hi[3:0], w_dec_lo[3:0]};
        r_corr <= w_dec_hi[5] | w_dec_lo[5];
        r_dbl  <= w_dec_hi[4] | w_dec_lo[4];
      end
    end
  end

  assign bus.data_o       = r_data;
  assign bus.valid_o      = r_valid;
  assign bus.corrected_o  = r_corr;
  assign bus.double_err_o = r_dbl;
  assign bus.frame_err_o  = r_frame_err;

endmodule
